// File: rtl/wbxbc_pkg.sv
// wbxbc_pkg: shared widths, payload/response structs and counter-width helper for the Wishbone pipe slice
package wbxbc_pkg;
    localparam int ADR_W     = 16;
    localparam int DAT_W     = 16;
    localparam int SEL_W     = 2;
    localparam int TGA_W     = 1;
    localparam int TGC_W     = 1;
    localparam int TGRD_W    = 1;
    localparam int TGWD_W    = 1;
    localparam int OUT_MAX_D = 4;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADR_W-1:0]  adr;
        logic [DAT_W-1:0]  dat;
        logic [TGA_W-1:0]  tga;
        logic [TGC_W-1:0]  tgc;
        logic [TGWD_W-1:0] tgd;
    } req_t;

    typedef struct packed {
        logic              ack;
        logic              err;
        logic              rty;
        logic [DAT_W-1:0]  dat;
        logic [TGRD_W-1:0] tgd;
    } rsp_t;

    function automatic int cnt_w(input int out_max);
        return $clog2(out_max + 1);
    endfunction
endpackage

// File: rtl/wbxbc_skid_buf.sv
// wbxbc_skid_buf: 2-entry valid/ready skid buffer with flush
//   clk, rst (async, active-high), flush (clears both entries on the next edge)
//   in_valid/in_data: producer side; caller must not push while the skid entry is full
//   out_ready: consumer accepts; out_valid/out_data: registered output entry
//   full_next: skid entry will be occupied after this edge (used for a registered stall)
module wbxbc_skid_buf #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 full_next
);
    logic                 skid_valid;
    logic [PAYLOAD_W-1:0] skid_data;
    logic                 adv;

    assign adv       = ~out_valid | out_ready;
    // a word only parks in the skid entry while the output entry is blocked
    assign full_next = ~flush & ~adv & (skid_valid | in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            skid_valid <= full_next;
            if (adv) begin
                out_valid <= skid_valid | in_valid;
                if (skid_valid | in_valid) out_data <= skid_valid ? skid_data : in_data;
            end
            if (~adv & in_valid & ~skid_valid) skid_data <= in_data;
        end
    end
endmodule

// File: rtl/wbxbc_pipe_slice.sv
// wbxbc_pipe_slice: pipelined Wishbone register slice between an initiator (itr_*) and a target (tgt_*)
//   clk_i, async_rst_i / sync_rst_i (active-high, identical effect)
//   itr_* inputs: request controls and payload; itr_* outputs: registered ack/err/rty/stall, read data/tag
//   tgt_* outputs: registered request controls and payload; tgt_* inputs: responses, stall, read data/tag
module wbxbc_pipe_slice
    import wbxbc_pkg::*;
#(
    parameter int ADR_WIDTH  = ADR_W,
    parameter int DAT_WIDTH  = DAT_W,
    parameter int SEL_WIDTH  = SEL_W,
    parameter int TGA_WIDTH  = TGA_W,
    parameter int TGC_WIDTH  = TGC_W,
    parameter int TGRD_WIDTH = TGRD_W,
    parameter int TGWD_WIDTH = TGWD_W,
    parameter int OUT_MAX    = OUT_MAX_D
) (
    input  logic                  clk_i,
    input  logic                  async_rst_i,
    input  logic                  sync_rst_i,
    input  logic                  itr_cyc_i,
    input  logic                  itr_stb_i,
    input  logic                  itr_we_i,
    input  logic                  itr_lock_i,
    input  logic [SEL_WIDTH-1:0]  itr_sel_i,
    input  logic [ADR_WIDTH-1:0]  itr_adr_i,
    input  logic [DAT_WIDTH-1:0]  itr_dat_i,
    input  logic [TGA_WIDTH-1:0]  itr_tga_i,
    input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
    input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
    output logic                  itr_ack_o,
    output logic                  itr_err_o,
    output logic                  itr_rty_o,
    output logic                  itr_stall_o,
    output logic [DAT_WIDTH-1:0]  itr_dat_o,
    output logic [TGRD_WIDTH-1:0] itr_tgd_o,
    output logic                  tgt_cyc_o,
    output logic                  tgt_stb_o,
    output logic                  tgt_we_o,
    output logic                  tgt_lock_o,
    output logic [SEL_WIDTH-1:0]  tgt_sel_o,
    output logic [ADR_WIDTH-1:0]  tgt_adr_o,
    output logic [DAT_WIDTH-1:0]  tgt_dat_o,
    output logic [TGA_WIDTH-1:0]  tgt_tga_o,
    output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
    output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
    input  logic                  tgt_ack_i,
    input  logic                  tgt_err_i,
    input  logic                  tgt_rty_i,
    input  logic                  tgt_stall_i,
    input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
    input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);
    localparam int CNT_W = cnt_w(OUT_MAX);

    req_t             req_in, req_out;
    rsp_t             rsp;
    logic             acc, dec, flush, full_next, term;
    logic [CNT_W-1:0] count, count_next;

    assign req_in     = '{we: itr_we_i, sel: itr_sel_i, adr: itr_adr_i, dat: itr_dat_i,
                          tga: itr_tga_i, tgc: itr_tgc_i, tgd: itr_tgd_i};
    assign acc        = itr_cyc_i & itr_stb_i & ~itr_stall_o;
    // dropping cyc abandons the whole cycle, queued words included
    assign flush      = sync_rst_i | ~itr_cyc_i;
    assign term       = tgt_ack_i | tgt_err_i | tgt_rty_i;
    // a termination that will be forwarded next cycle retires one request now
    assign dec        = term & tgt_cyc_o & itr_cyc_i & (count != '0);
    assign count_next = flush ? '0 : count + CNT_W'(acc) - CNT_W'(dec);

    wbxbc_skid_buf #(.PAYLOAD_W($bits(req_t))) u_skid (
        .clk       (clk_i),
        .rst       (async_rst_i),
        .flush     (flush),
        .in_valid  (acc),
        .in_data   (req_in),
        .out_ready (~tgt_stall_i),
        .out_valid (tgt_stb_o),
        .out_data  (req_out),
        .full_next (full_next)
    );

    assign {tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o} = req_out;
    assign {itr_ack_o, itr_err_o, itr_rty_o, itr_dat_o, itr_tgd_o} = rsp;

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            count       <= '0;
            itr_stall_o <= 1'b1;
            tgt_cyc_o   <= 1'b0;
            tgt_lock_o  <= 1'b0;
            rsp         <= '0;
        end else if (sync_rst_i) begin
            count       <= '0;
            itr_stall_o <= 1'b1;
            tgt_cyc_o   <= 1'b0;
            tgt_lock_o  <= 1'b0;
            rsp         <= '0;
        end else begin
            count       <= count_next;
            itr_stall_o <= full_next | (count_next == CNT_W'(OUT_MAX));
            tgt_cyc_o   <= itr_cyc_i;
            tgt_lock_o  <= itr_lock_i;
            rsp.ack     <= tgt_ack_i & tgt_cyc_o & itr_cyc_i;
            rsp.err     <= tgt_err_i & tgt_cyc_o & itr_cyc_i;
            rsp.rty     <= tgt_rty_i & tgt_cyc_o & itr_cyc_i;
            if (term) begin
                rsp.dat <= tgt_dat_i;
                rsp.tgd <= tgt_tgd_i;
            end
        end
    end
endmodule

// File: tb/tb_wbxbc_pipe_slice.sv
// tb_wbxbc_pipe_slice: scoreboard bench for wbxbc_pipe_slice with a simple target model
module tb_wbxbc_pipe_slice;
    logic        clk_i = 1'b0;
    logic        async_rst_i, sync_rst_i;
    logic        itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i;
    logic [1:0]  itr_sel_i;
    logic [15:0] itr_adr_i, itr_dat_i;
    logic        itr_tga_i, itr_tgc_i, itr_tgd_i;
    logic        itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
    logic [15:0] itr_dat_o;
    logic        itr_tgd_o;
    logic        tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
    logic [1:0]  tgt_sel_o;
    logic [15:0] tgt_adr_o, tgt_dat_o;
    logic        tgt_tga_o, tgt_tgc_o, tgt_tgd_o;
    logic        tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i;
    logic [15:0] tgt_dat_i;
    logic        tgt_tgd_i;

    always #5 clk_i = ~clk_i;

    wbxbc_pipe_slice dut (
        .clk_i(clk_i), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
        .itr_cyc_i(itr_cyc_i), .itr_stb_i(itr_stb_i), .itr_we_i(itr_we_i), .itr_lock_i(itr_lock_i),
        .itr_sel_i(itr_sel_i), .itr_adr_i(itr_adr_i), .itr_dat_i(itr_dat_i),
        .itr_tga_i(itr_tga_i), .itr_tgc_i(itr_tgc_i), .itr_tgd_i(itr_tgd_i),
        .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o), .itr_rty_o(itr_rty_o), .itr_stall_o(itr_stall_o),
        .itr_dat_o(itr_dat_o), .itr_tgd_o(itr_tgd_o),
        .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_we_o(tgt_we_o), .tgt_lock_o(tgt_lock_o),
        .tgt_sel_o(tgt_sel_o), .tgt_adr_o(tgt_adr_o), .tgt_dat_o(tgt_dat_o),
        .tgt_tga_o(tgt_tga_o), .tgt_tgc_o(tgt_tgc_o), .tgt_tgd_o(tgt_tgd_o),
        .tgt_ack_i(tgt_ack_i), .tgt_err_i(tgt_err_i), .tgt_rty_i(tgt_rty_i), .tgt_stall_i(tgt_stall_i),
        .tgt_dat_i(tgt_dat_i), .tgt_tgd_i(tgt_tgd_i)
    );

    typedef struct {logic we; logic [15:0] adr; logic [15:0] dat;} itr_e;
    typedef struct {logic [2:0] kind; logic [15:0] dat; logic tgd; int when;} rsp_e;

    itr_e        iq[$];
    logic [37:0] exp_req[$];
    rsp_e        exp_rsp[$];
    rsp_e        tq[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          stall_left = 0, acc_cnt = 0, resp_seen = 0;
    int          last_acc = 0, last_stb = 0, last_rsp = 0;
    logic        tgt_hold = 1'b0, saw_stall = 1'b0;
    logic [15:0] err_adr = 16'hFFFF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] pay_of(input itr_e r);
        return {r.we, 2'b11, r.adr, r.dat, r.adr[0], r.adr[1], r.adr[2]};
    endfunction

    // target replies with data 0xA0+adr, tag adr[0], and err on err_adr ({rty,err,ack})
    function automatic rsp_e rsp_of(input logic [15:0] adr);
        rsp_e r;
        r.kind = (adr == err_adr) ? 3'b010 : 3'b001;
        r.dat  = 16'hA0 + adr;
        r.tgd  = adr[0];
        r.when = 0;
        return r;
    endfunction

    task automatic push(input logic we, input logic [15:0] adr, input logic [15:0] dat);
        itr_e r;
        r.we = we; r.adr = adr; r.dat = dat;
        iq.push_back(r);
    endtask

    task automatic step();
        rsp_e r;
        itr_e q;
        @(negedge clk_i);
        cyc++;
        if (itr_stall_o) saw_stall = 1'b1;
        if (itr_ack_o | itr_err_o | itr_rty_o) begin
            resp_seen++;
            if (exp_rsp.size() == 0) check("rsp_unexp", {itr_rty_o, itr_err_o, itr_ack_o}, 0);
            else begin
                r = exp_rsp.pop_front();
                check("rsp_kind", {itr_rty_o, itr_err_o, itr_ack_o}, r.kind);
                check("rsp_dat", {itr_tgd_o, itr_dat_o}, {r.tgd, r.dat});
                last_rsp = cyc;
            end
        end
        tgt_stall_i = tgt_stb_o && stall_left > 0;
        if (tgt_stall_i) stall_left--;
        {tgt_rty_i, tgt_err_i, tgt_ack_i} = 3'b000;
        if (!tgt_hold && tq.size() > 0 && tq[0].when <= cyc) begin
            r = tq.pop_front();
            {tgt_rty_i, tgt_err_i, tgt_ack_i} = r.kind;
            tgt_dat_i = r.dat;
            tgt_tgd_i = r.tgd;
        end
        if (tgt_stb_o && !tgt_stall_i) begin
            if (exp_req.size() == 0) check("req_unexp", tgt_stb_o, 0);
            else check("req_pay", {tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o},
                       exp_req.pop_front());
            r = rsp_of(tgt_adr_o);
            r.when = cyc + 1;
            tq.push_back(r);
            last_stb = cyc;
        end
        itr_stb_i = iq.size() > 0;
        if (itr_stb_i) begin
            q = iq[0];
            itr_we_i = q.we; itr_adr_i = q.adr; itr_dat_i = q.dat; itr_sel_i = 2'b11;
            itr_tga_i = q.adr[0]; itr_tgc_i = q.adr[1]; itr_tgd_i = q.adr[2];
            if (itr_cyc_i && !itr_stall_o) begin
                exp_req.push_back(pay_of(q));
                exp_rsp.push_back(rsp_of(q.adr));
                void'(iq.pop_front());
                acc_cnt++;
                last_acc = cyc;
            end
        end
    endtask

    task automatic run_idle();
        int n = 0;
        while ((iq.size() + exp_req.size() + exp_rsp.size() + tq.size()) != 0 && n < 200) begin
            step();
            n++;
        end
        check("idle", iq.size() + exp_req.size() + exp_rsp.size() + tq.size(), 0);
    endtask

    task automatic clear_all();
        iq.delete(); exp_req.delete(); exp_rsp.delete(); tq.delete();
        stall_left = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        async_rst_i = 1'b1; sync_rst_i = 1'b0;
        itr_cyc_i = 1'b0; itr_stb_i = 1'b0; itr_we_i = 1'b0; itr_lock_i = 1'b0;
        itr_sel_i = '0; itr_adr_i = '0; itr_dat_i = '0; itr_tga_i = 1'b0; itr_tgc_i = 1'b0; itr_tgd_i = 1'b0;
        tgt_ack_i = 1'b0; tgt_err_i = 1'b0; tgt_rty_i = 1'b0; tgt_stall_i = 1'b0; tgt_dat_i = '0; tgt_tgd_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_stall", itr_stall_o, 1);
        check("rst_outs", {itr_ack_o, itr_err_o, itr_rty_o, itr_dat_o, itr_tgd_o, tgt_cyc_o, tgt_stb_o, tgt_we_o,
                           tgt_lock_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o}, 0);
        async_rst_i = 1'b0;
        step();
        check("stall_fall", itr_stall_o, 0);
        itr_cyc_i = 1'b1;

        itr_lock_i = 1'b1;
        push(1'b1, 16'h10, 16'hBEEF);
        run_idle();
        check("lat_stb", last_stb - last_acc, 1);
        check("lat_ack", last_rsp - last_acc, 3);
        check("lock", tgt_lock_o, 1);
        check("cnt_wr", dut.count, 0);
        itr_lock_i = 1'b0;

        saw_stall = 1'b0;
        stall_left = 2;
        for (int i = 0; i < 4; i++) push(1'b0, 16'(i), 16'h0);
        run_idle();
        check("skid_stall", saw_stall, 1);
        check("cnt_rd", dut.count, 0);

        tgt_hold = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) push(1'b0, 16'h30 + 16'(i), 16'h0);
        repeat (10) step();
        check("thr_acc", acc_cnt, 4);
        check("thr_stall", itr_stall_o, 1);
        check("thr_cnt", dut.count, 4);
        tgt_hold = 1'b0;
        step();
        check("thr_hold", itr_stall_o, 1);
        step();
        check("thr_drop", itr_stall_o, 0);
        run_idle();

        tgt_hold = 1'b1;
        push(1'b0, 16'h40, 16'h0);
        push(1'b0, 16'h41, 16'h0);
        for (int n = 0; n < 10 && (iq.size() + exp_req.size()) != 0; n++) step();
        itr_cyc_i = 1'b0;
        exp_rsp.delete();
        step();
        check("ab_cyc", tgt_cyc_o, 0);
        check("ab_stb", tgt_stb_o, 0);
        check("ab_cnt", dut.count, 0);
        resp_seen = 0;
        tgt_hold = 1'b0;
        repeat (4) step();
        check("ab_late", resp_seen, 0);
        check("ab_tq", tq.size(), 0);
        itr_cyc_i = 1'b1;

        err_adr = 16'h21;
        for (int i = 0; i < 3; i++) push(1'b0, 16'h20 + 16'(i), 16'h0);
        run_idle();
        err_adr = 16'hFFFF;

        for (int i = 0; i < 4; i++) push(1'b1, 16'h50 + 16'(i), 16'h1000 + 16'(i));
        repeat (2) step();
        async_rst_i = 1'b1;
        #1;
        check("arst_stall", itr_stall_o, 1);
        check("arst_outs", {itr_ack_o, itr_err_o, itr_rty_o, itr_dat_o, itr_tgd_o, tgt_cyc_o, tgt_stb_o, tgt_we_o,
                            tgt_lock_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o}, 0);
        clear_all();
        step();
        async_rst_i = 1'b0;
        step();
        check("arst_fall", itr_stall_o, 0);
        push(1'b1, 16'h60, 16'h1234);
        run_idle();
        check("cnt_arst", dut.count, 0);

        tgt_hold = 1'b1;
        push(1'b0, 16'h70, 16'h0);
        push(1'b0, 16'h71, 16'h0);
        repeat (3) step();
        sync_rst_i = 1'b1;
        clear_all();
        step();
        check("srst_stall", itr_stall_o, 1);
        check("srst_ctl", {tgt_cyc_o, tgt_stb_o, tgt_adr_o}, 0);
        check("srst_cnt", dut.count, 0);
        sync_rst_i = 1'b0;
        tgt_hold = 1'b0;
        tq.delete();
        step();
        check("srst_fall", itr_stall_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
